// File: rtl/dsu_stage.sv
// Data staging unit: packs LANES scalar elements into one vector word and
// queues finished vectors in a first-word-fall-through FIFO for the compute array.

module dsu_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] merged,
  output logic              mbit
);
  logic [DATA_W-1:0] data_q;
  logic              vld_q;

  // clr wins over wr so the lane that commits a vector starts the next one empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (wr) begin
      data_q <= din;
      vld_q  <= 1'b1;
    end
  end

  assign merged = wr ? din : data_q;
  assign mbit   = wr | vld_q;
endmodule

module dsu_stage #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_mask,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [LANES-1:0][DATA_W-1:0] data;
    logic [LANES-1:0]             mask;
    logic                         last;
  } vec_t;

  logic [LCW-1:0]               lane_cnt;
  logic [LANES-1:0][DATA_W-1:0] pack_nxt;
  logic [LANES-1:0]             mask_nxt;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         accept, commit, push, pop;
  vec_t                         mem [DEPTH];
  vec_t                         wr_vec, head;

  // in_ready depends only on registered count, never on out_ready
  assign in_ready = !rst && (fifo_count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign commit   = accept && ((lane_cnt == LCW'(LANES - 1)) || in_last);
  assign push     = commit;
  assign pop      = out_valid && out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsu_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr     (accept && (lane_cnt == LCW'(i))),
      .clr    (commit),
      .din    (in_data),
      .merged (pack_nxt[i]),
      .mbit   (mask_nxt[i])
    );
  end

  assign wr_vec = '{data: pack_nxt, mask: mask_nxt, last: in_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lane_cnt <= '0;
    else if (commit) lane_cnt <= '0;
    else if (accept) lane_cnt <= lane_cnt + LCW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_vec;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_count != '0);
  assign out_data  = head.data;
  assign out_mask  = head.mask;
  assign out_last  = head.last;
endmodule

// File: tb/tb_dsu_stage.sv
// Directed bench for dsu_stage: packing, padding, FIFO full/wrap, async reset, backpressure.

module tb_dsu_stage;
  logic        clk, rst;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic [2:0]  fifo_count;

  int nchk = 0;
  int nerr = 0;
  int pidx;
  logic [31:0] held_d;
  logic [3:0]  held_m;
  logic        held_l;

  dsu_stage #(.DATA_W(8), .LANES(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_last(out_last), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive inputs at a negedge, return at the following negedge (one active edge later)
  task automatic step(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
  endtask

  function automatic logic [31:0] vexp(input int k);
    logic [7:0] b;
    b = 8'(k * 16);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // 1: full vector
    out_ready = 1'b1;
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
    chk("t1_no_valid_yet", out_valid, 0);
    step(1, 8'h44, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h44332211);
    chk("t1_mask", out_mask, 4'b1111);
    chk("t1_last", out_last, 0);
    chk("t1_count", fifo_count, 1);
    step(0, 8'h00, 0);
    chk("t1_count_after_pop", fifo_count, 0);

    // 2: partial vector closed by in_last, next element in lane 0
    step(1, 8'hAA, 0); step(1, 8'hBB, 1);
    chk("t2_data", out_data, 32'h0000BBAA);
    chk("t2_mask", out_mask, 4'b0011);
    chk("t2_last", out_last, 1);
    step(1, 8'h5C, 1);
    chk("t2_count", fifo_count, 1);
    chk("t2_lane0_data", out_data, 32'h0000005C);
    chk("t2_lane0_mask", out_mask, 4'b0001);
    step(0, 8'h00, 0);
    chk("t2_drain", fifo_count, 0);

    // 3: fill FIFO with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) step(1, 8'(i + 1), 0);
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) step(1, 8'd17, 0);
    chk("t3_hold_count", fifo_count, 4);
    chk("t3_head", out_data, 32'h04030201);
    out_ready = 1'b1;
    step(1, 8'd17, 0);
    chk("t3_pop_count", fifo_count, 3);
    chk("t3_ready_back", in_ready, 1);
    chk("t3_head2", out_data, 32'h08070605);
    step(1, 8'd17, 0);
    chk("t3_head3", out_data, 32'h0C0B0A09);
    step(1, 8'd18, 0);
    chk("t3_head4", out_data, 32'h100F0E0D);
    step(1, 8'd19, 0);
    chk("t3_empty", out_valid, 0);
    step(1, 8'd20, 0);
    chk("t3_tail_data", out_data, 32'h14131211);
    chk("t3_tail_mask", out_mask, 4'b1111);
    step(0, 8'h00, 0);
    chk("t3_drain", fifo_count, 0);

    // 4: simultaneous push/pop at count 2, order kept across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) step(1, 8'(k * 16 + j), 0);
    chk("t4_count2", fifo_count, 2);
    pidx = 0;
    for (int k = 2; k < 12; k++)
      for (int j = 0; j < 4; j++) begin
        out_ready = (j == 3);
        if (j == 3) begin
          chk($sformatf("t4_order%0d", pidx), out_data, vexp(pidx));
          pidx++;
        end
        step(1, 8'(k * 16 + j), 0);
        if (j == 3) chk($sformatf("t4_steady%0d", k), fifo_count, 2);
      end
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("t4_order%0d", pidx), out_data, vexp(pidx));
      pidx++;
      step(0, 8'h00, 0);
    end
    chk("t4_drain", fifo_count, 0);

    // 5: async reset mid-pack with one vector stored
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 8'(8'hE0 + i), 0);
    chk("t5_pre_count", fifo_count, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0); step(1, 8'h04, 0);
    chk("t5_data", out_data, 32'h04030201);
    chk("t5_mask", out_mask, 4'b1111);
    chk("t5_count", fifo_count, 1);
    step(0, 8'h00, 0);

    // 6: backpressure hold with two vectors queued
    out_ready = 1'b0;
    step(1, 8'h61, 0); step(1, 8'h62, 1);
    step(1, 8'h71, 0); step(1, 8'h72, 0); step(1, 8'h73, 0); step(1, 8'h74, 0);
    held_d = 32'h00006261; held_m = 4'b0011; held_l = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(0, 8'h00, 0);
      chk($sformatf("t6_hold_data%0d", c), out_data, held_d);
      chk($sformatf("t6_hold_mask%0d", c), out_mask, held_m);
      chk($sformatf("t6_hold_last%0d", c), out_last, held_l);
    end
    chk("t6_count_held", fifo_count, 2);
    out_ready = 1'b1;
    step(0, 8'h00, 0);
    out_ready = 1'b0;
    chk("t6_single_pop", fifo_count, 1);
    chk("t6_next_head", out_data, 32'h74737271);
    chk("t6_next_last", out_last, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
